// File: rtl/array_alloc_arbiter_if.sv
// Request/grant bundle between requesters and the array handle allocator.
// Requests are level-held until granted; grant is a one-cycle pulse.
interface array_alloc_arbiter_if #(
  parameter int MemoryElementWidth = 12,
  parameter int NReq               = 4
);
  logic [NReq-1:0]                    allocReq;
  logic [NReq-1:0]                    freeReq;
  logic [NReq*MemoryElementWidth-1:0] freeHandle;
  logic [NReq-1:0]                    grant;
  logic [MemoryElementWidth-1:0]      grantHandle;
  logic                               grantIsFree;
  logic                               error;
  logic                               full;
  logic [MemoryElementWidth:0]        inUse;

  modport master (
    output allocReq, freeReq, freeHandle,
    input  grant, grantHandle, grantIsFree, error, full, inUse
  );

  modport slave (
    input  allocReq, freeReq, freeHandle,
    output grant, grantHandle, grantIsFree, error, full, inUse
  );
endinterface

// File: rtl/array_alloc_arbiter.sv
// Round-robin allocator/freer of array handles with a LIFO free list; grant one cycle after decision.
// One operation per two cycles; frees beat allocs, allocs stall (no grant) while full.
module array_alloc_arbiter #(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays            = 16,
  parameter int NReq               = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  array_alloc_arbiter_if.slave  bus
);
  localparam int         W   = MemoryElementWidth;
  localparam int         AW  = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam int         RW  = (NReq > 1) ? $clog2(NReq) : 1;
  localparam logic [W:0] NA  = (W+1)'(NArrays);
  localparam logic [W:0] ONE = (W+1)'(1);

  typedef enum logic {IDLE, ACK} state_t;

  state_t              state, state_nxt;
  logic [W:0]          allocs, freedTop;
  logic [W-1:0]        stack [NArrays];
  logic [NArrays-1:0]  bitmap;
  logic [RW-1:0]       rrPtr;
  logic [NReq-1:0]     grantR;
  logic [W-1:0]        handleR;
  logic                isFreeR, errorR;

  logic                full;
  logic                anyFree, found, doOp, freeLegal;
  logic [NReq-1:0]     mask;
  logic [RW-1:0]       win;
  logic [W-1:0]        fh, allocHandle;

  assign full = (freedTop == '0) && (allocs == NA);

  // Pending frees mask out every alloc; a full pool masks allocs entirely.
  always_comb begin
    anyFree = |bus.freeReq;
    mask    = anyFree ? bus.freeReq : (full ? '0 : bus.allocReq);
    win     = rrPtr;
    found   = 1'b0;
    for (int i = NReq-1; i >= 0; i--) begin
      if (mask[i] && i <= int'(rrPtr)) begin
        win   = RW'(i);
        found = 1'b1;
      end
    end
    for (int i = NReq-1; i >= 0; i--) begin
      if (mask[i] && i > int'(rrPtr)) begin
        win   = RW'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    fh          = bus.freeHandle[int'(win)*W +: W];
    freeLegal   = ({1'b0, fh} < allocs) && bitmap[fh[AW-1:0]];
    allocHandle = (freedTop != '0) ? stack[AW'(freedTop - ONE)] : allocs[W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    doOp      = 1'b0;
    case (state)
      IDLE: if (found) begin
        doOp      = 1'b1;
        state_nxt = ACK;
      end
      ACK:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      allocs   <= '0;
      freedTop <= '0;
      bitmap   <= '0;
      rrPtr    <= RW'(NReq-1);
      grantR   <= '0;
      handleR  <= '0;
      isFreeR  <= 1'b0;
      errorR   <= 1'b0;
    end else if (doOp) begin
      rrPtr       <= win;
      grantR      <= '0;
      grantR[win] <= 1'b1;
      handleR     <= anyFree ? fh : allocHandle;
      isFreeR     <= anyFree;
      errorR      <= anyFree && !freeLegal;
      if (anyFree) begin
        if (freeLegal) begin
          freedTop               <= freedTop + ONE;
          bitmap[fh[AW-1:0]]     <= 1'b0;
        end
      end else begin
        if (freedTop != '0) freedTop <= freedTop - ONE;
        else                allocs   <= allocs + ONE;
        bitmap[allocHandle[AW-1:0]] <= 1'b1;
      end
    end else begin
      grantR  <= '0;
      handleR <= '0;
      isFreeR <= 1'b0;
      errorR  <= 1'b0;
    end
  end

  // Free-list storage carries no reset; only entries below freedTop are ever read.
  always_ff @(posedge clock) begin
    if (!reset && doOp && anyFree && freeLegal)
      stack[freedTop[AW-1:0]] <= fh;
  end

  assign bus.grant       = grantR;
  assign bus.grantHandle = handleR;
  assign bus.grantIsFree = isFreeR;
  assign bus.error       = errorR;
  assign bus.full        = full;
  assign bus.inUse       = allocs - freedTop;
endmodule

// File: tb/tb_array_alloc_arbiter.sv
// Randomized requesters against a transaction-level handle-pool model with a queued scoreboard.
module tb_array_alloc_arbiter;
  localparam int W  = 4;
  localparam int NA = 8;
  localparam int NR = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  array_alloc_arbiter_if #(.MemoryElementWidth(W), .NReq(NR)) bus();

  array_alloc_arbiter #(.MemoryElementWidth(W), .NArrays(NA), .NReq(NR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [NR-1:0] g;
    logic [W-1:0]  h;
    logic          f;
    logic          e;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;

  // Pool model: never-used counter, LIFO of freed handles, ownership flags.
  int   m_allocs;
  int   m_freed[$];
  bit   m_allocd[NA];
  int   m_rr;
  bit   busy;
  int   busy_w;
  bit   want_rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_full();
    return (m_freed.size() == 0) && (m_allocs == NA);
  endfunction

  function automatic void model_reset();
    m_allocs = 0;
    m_freed.delete();
    foreach (m_allocd[i]) m_allocd[i] = 1'b0;
    m_rr = NR - 1;
    busy = 1'b0;
    expq.delete();
  endfunction

  task automatic add_requests(input int alloc_pct);
    int al[$];
    int h, r;
    for (int i = 0; i < NR; i++) begin
      if (!bus.allocReq[i] && !bus.freeReq[i] && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 99) < alloc_pct) begin
          bus.allocReq[i] = 1'b1;
        end else begin
          al.delete();
          foreach (m_allocd[j]) if (m_allocd[j]) al.push_back(j);
          r = $urandom_range(0, 9);
          if (r < 7 && al.size() > 0) h = al[$urandom_range(0, al.size()-1)];
          else if (r < 9)             h = $urandom_range(0, NA-1);
          else                        h = $urandom_range(0, (1 << W) - 1);
          bus.freeHandle[i*W +: W] = W'(h);
          bus.freeReq[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic decide();
    logic [NR-1:0] msk, gv;
    bit   anyf, legal;
    int   w, h;
    exp_t e;
    anyf = |bus.freeReq;
    msk  = anyf ? bus.freeReq : (model_full() ? '0 : bus.allocReq);
    if (msk == '0) return;
    w = -1;
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (m_rr + k) % NR;
      if (w < 0 && msk[i]) w = i;
    end
    m_rr   = w;
    busy   = 1'b1;
    busy_w = w;
    gv     = '0;
    gv[w]  = 1'b1;
    e.g    = gv;
    e.f    = anyf;
    if (anyf) begin
      h     = int'(bus.freeHandle[w*W +: W]);
      legal = (h < m_allocs) && (h < NA) && m_allocd[h];
      if (legal) begin
        m_freed.push_back(h);
        m_allocd[h] = 1'b0;
      end
      e.e = !legal;
    end else begin
      if (m_freed.size() > 0) h = m_freed.pop_back();
      else                    h = m_allocs++;
      m_allocd[h] = 1'b1;
      e.e = 1'b0;
    end
    e.h = W'(h);
    expq.push_back(e);
  endtask

  always @(posedge clock) begin : monitor
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("grant",       32'(bus.grant),       32'(e.g));
      chk("grantHandle", 32'(bus.grantHandle), 32'(e.h));
      chk("grantIsFree", 32'(bus.grantIsFree), 32'(e.f));
      chk("error",       32'(bus.error),       32'(e.e));
    end else begin
      chk("grant_quiet", 32'(bus.grant), 32'(0));
      chk("error_quiet", 32'(bus.error), 32'(0));
    end
    chk("inUse", 32'(bus.inUse), 32'(m_allocs - m_freed.size()));
    chk("full",  32'(bus.full),  32'(model_full()));
  end

  initial begin
    bus.allocReq   = '0;
    bus.freeReq    = '0;
    bus.freeHandle = '0;
    want_rst       = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset        = 1'b0;
    bus.allocReq = 4'b0111;
    decide();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      if (reset) reset = 1'b0;
      if (cyc % 700 == 350) want_rst = 1'b1;
      if (busy) begin
        bus.allocReq[busy_w] = 1'b0;
        bus.freeReq[busy_w]  = 1'b0;
        busy = 1'b0;
        if (want_rst) begin
          want_rst      = 1'b0;
          reset         = 1'b1;
          bus.allocReq  = '0;
          bus.freeReq   = '0;
          model_reset();
        end else begin
          add_requests((cyc / 500) % 2 == 0 ? 70 : 40);
        end
      end else begin
        add_requests((cyc / 500) % 2 == 0 ? 70 : 40);
        decide();
      end
    end
    @(negedge clock);
    bus.allocReq = '0;
    bus.freeReq  = '0;
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/array_alloc_arbiter.md
ARRAY_ALLOC_ARBITER -- requirements
Module: array_alloc_arbiter

Interface
REQ-001 The block SHALL have parameter MemoryElementWidth, default 12, giving the array handle width in bits.
REQ-002 The block SHALL have parameter NArrays, default 16, giving the maximum number of array handles, with NArrays <= 2**MemoryElementWidth.
REQ-003 The block SHALL have parameter NReq, default 4, giving the number of requesters.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port allocReq, input, NReq bits: per-requester allocate request, level, held until granted.
REQ-007 The block SHALL have port freeReq, input, NReq bits: per-requester free request, level, held until granted.
REQ-008 The block SHALL have port freeHandle, input, NReq*MemoryElementWidth bits: requester i's handle to free, at bits [i*W +: W].
REQ-009 The block SHALL have port grant, output, NReq bits: one-hot, one-cycle grant pulse.
REQ-010 The block SHALL have port grantHandle, output, MemoryElementWidth bits: handle allocated or freed, valid while grant is nonzero.
REQ-011 The block SHALL have port grantIsFree, output, 1 bit: 1 if the current grant is a free, 0 if it is an allocate.
REQ-012 The block SHALL have port error, output, 1 bit: one-cycle pulse flagging an illegal free.
REQ-013 The block SHALL have port full, output, 1 bit: high when no handle can be allocated.
REQ-014 The block SHALL have port inUse, output, MemoryElementWidth+1 bits: count of handles currently allocated.

Function
REQ-015 The block SHALL hold the following state: allocs counter (next never-used handle), freed-handle LIFO stack of depth NArrays with pointer freedTop, allocated bitmap of NArrays bits, round-robin pointer rrPtr, and a two-state FSM IDLE/ACK.
REQ-016 In IDLE with at least one serviceable request, the block SHALL choose one winner, perform its operation, register grant/grantHandle/grantIsFree/error, and move to ACK.
REQ-017 In IDLE with no serviceable request, the block SHALL stay in IDLE with grant=0.
REQ-018 In ACK the block SHALL drive the registered grant for exactly one cycle, ignore all requests, and return to IDLE.
REQ-019 Consequences of REQ-016 to REQ-018: maximum throughput is one operation per 2 cycles, and grant appears one cycle after the IDLE decision cycle.
REQ-020 Requesters SHALL deassert their req in the cycle after the grant pulse.
REQ-021 Any pending freeReq SHALL take priority over every allocReq.
REQ-022 Within the chosen type, the winner SHALL be the first requester asserting that type searching upward from rrPtr+1 modulo NReq; rrPtr SHALL then be set to the winner index.
REQ-023 Allocate: if freedTop>0, decrement freedTop and return stack[freedTop]; otherwise return allocs and increment allocs.
REQ-024 On every allocate, the block SHALL set the handle's bitmap bit and increment inUse.
REQ-025 full SHALL equal (freedTop==0 && allocs==NArrays), combinationally from registered state.
REQ-026 While full=1, allocReqs SHALL NOT be serviceable: they stay pending with no grant and no error, and frees are still served.
REQ-027 A legal free (handle<allocs and bitmap bit set) SHALL push the handle at stack[freedTop], increment freedTop, clear the bitmap bit, and decrement inUse.
REQ-028 An illegal free (handle>=allocs, or bitmap bit clear) SHALL still be granted, with grantHandle = the offending handle and error=1 in the grant cycle, and SHALL leave all other state unchanged.
REQ-029 The stack SHALL never overflow, because REQ-027 and REQ-028 bound pushes to allocated handles.
REQ-030 inUse SHALL always equal allocs minus freedTop.

Reset
REQ-031 When reset=1 at a rising edge, the block SHALL go to IDLE with allocs=0, freedTop=0, bitmap all 0, inUse=0, rrPtr=NReq-1, grant=0, grantHandle=0, grantIsFree=0, error=0.
REQ-032 Reset SHALL take precedence over any operation, including an ACK in progress; the pending grant SHALL be dropped and not re-issued.
REQ-033 Stack contents need not be cleared by reset.

Verification
REQ-034 Requester 0 doing alloc,free,alloc,free,alloc,free after reset -> alloc grants give handle 0 each time; inUse toggles 1,0; error never pulses.
REQ-035 Three allocs, then free 1, free 2, then two allocs -> handles 0,1,2, then 2, then 1 (LIFO); final inUse=3.
REQ-036 allocReq=4'b0111 held from reset -> grants 0001,0010,0100 on cycles 2,4,6 with handles 0,1,2.
REQ-037 Same cycle: req1 freeing handle 0 and req0 allocating -> free granted first; the following alloc returns handle 0.
REQ-038 NArrays=4: allocate 0..3, then a fifth alloc -> full=1 and no grant for 10 cycles; then free 3 -> the pending alloc is granted handle 3 and full returns to 1.
REQ-039 Free 2 twice, then free 9 with allocs=4 -> second free 2 and free 9 each give error=1 with grant, and inUse is unchanged; reset asserted during ACK -> grant=0 next cycle and inUse=0.
